// File: rtl/pbit_mult_request_scheduler.sv
// Round-robin scheduler sharing one p-bit multiplier network and its result interpreter.
// Optional RUN-state watchdog is compiled in with `define PBIT_TIMEOUT_EN.
module pbit_mult_request_scheduler #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned OPW            = 2,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*OPW-1:0]       opa_flat,
  input  logic [N_REQ*OPW-1:0]       opb_flat,
  output logic [N_REQ-1:0]           ack,
  output logic [2*OPW-1:0]           res_data,
  output logic                       res_err,
  output logic                       clamp_en,
  output logic [OPW-1:0]             clamp_a,
  output logic [OPW-1:0]             clamp_b,
  output logic                       interp_rst,
  output logic                       pending_request,
  input  logic                       valid_res,
  input  logic [2*OPW-1:0]           result,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned GW  = $clog2(N_REQ);
  localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);

  if (N_REQ < 2) begin : g_bad_nreq
    $error("N_REQ must be at least 2");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t           state;
  logic [GW-1:0]    ptr;
  logic [SCW-1:0]   settle_cnt;
  logic [GW-1:0]    pick;
  logic             found;

`ifdef PBIT_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0]   run_cnt;
`else
  assign res_err = 1'b0;
`endif

  // Search starts one past the last grant and wraps, so every requester is served in turn.
  always_comb begin
    int unsigned   idx;
    logic [GW-1:0] cand;
    idx   = 0;
    cand  = '0;
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = GW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state           <= IDLE;
      ptr             <= GW'(N_REQ - 1);
      settle_cnt      <= '0;
      grant_id        <= '0;
      clamp_a         <= '0;
      clamp_b         <= '0;
      clamp_en        <= 1'b0;
      interp_rst      <= 1'b0;
      pending_request <= 1'b0;
      ack             <= '0;
      res_data        <= '0;
      busy            <= 1'b0;
`ifdef PBIT_TIMEOUT_EN
      res_err         <= 1'b0;
      run_cnt         <= '0;
`endif
    end else begin
      interp_rst <= 1'b0;
      ack        <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id   <= pick;
            ptr        <= pick;
            clamp_a    <= opa_flat[pick*OPW +: OPW];
            clamp_b    <= opb_flat[pick*OPW +: OPW];
            clamp_en   <= 1'b1;
            interp_rst <= 1'b1;
            busy       <= 1'b1;
            state      <= FLUSH;
          end
        end
        FLUSH: begin
          settle_cnt <= SCW'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            pending_request <= 1'b1;
            state           <= RUN;
`ifdef PBIT_TIMEOUT_EN
            run_cnt         <= '0;
`endif
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        RUN: begin
          if (valid_res) begin
            res_data        <= result;
            ack[grant_id]   <= 1'b1;
            clamp_en        <= 1'b0;
            pending_request <= 1'b0;
            state           <= RESP;
`ifdef PBIT_TIMEOUT_EN
          end else if (run_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
            // Abort: report an error and flush the interpreter so it starts clean next job.
            res_data        <= '0;
            res_err         <= 1'b1;
            interp_rst      <= 1'b1;
            ack[grant_id]   <= 1'b1;
            clamp_en        <= 1'b0;
            pending_request <= 1'b0;
            state           <= RESP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
`ifdef PBIT_TIMEOUT_EN
          res_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
